// File: rtl/add_err_pkg.sv
// Shared types and helpers for the ADD-path error accounting / interrupt block.
package add_err_pkg;

    typedef enum logic [1:0] {
        OP_NOP = 2'b00,
        OP_ADD = 2'b01,
        OP_SUB = 2'b10,
        OP_MUL = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ARM    = 2'b01,
        ASSERT = 2'b10
    } irq_state_e;

    // All-ones value for a counter of width w (w <= 32).
    function automatic logic [31:0] cnt_max(input int unsigned w);
        return (32'(1) << w) - 32'(1);
    endfunction

endpackage

// File: rtl/add_err_sat_cnt.sv
// Saturating up-counter with sticky saturation flag; clear wins over hold,
// and clear together with increment restarts the count at one.
module add_err_sat_cnt
    import add_err_pkg::*;
#(
    parameter int unsigned W = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         inc_i,
    input  logic         clr_i,
    output logic [W-1:0] cnt_o,
    output logic         sat_o
);

    localparam logic [W-1:0] CntMax = W'(cnt_max(W));

    logic [W-1:0] cnt_q, cnt_d;
    logic         sat_q, sat_d;

    always_comb begin
        cnt_d = cnt_q;
        sat_d = sat_q;
        if (clr_i) begin
            cnt_d = inc_i ? W'(1) : '0;
            sat_d = 1'b0;
        end else if (inc_i) begin
            if (cnt_q == CntMax) begin
                sat_d = 1'b1;
            end else begin
                cnt_d = cnt_q + W'(1);
                if (cnt_q == CntMax - W'(1)) begin
                    sat_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            sat_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            sat_q <= sat_d;
        end
    end

    assign cnt_o = cnt_q;
    assign sat_o = sat_q;

endmodule

// File: rtl/add_err_irq_ctrl.sv
// Counts uncorrectable errors on ADD requests and raises a held level interrupt
// two clocks after the error, capturing the address of the arming request.
module add_err_irq_ctrl
    import add_err_pkg::*;
#(
    parameter int unsigned CNT_W  = 16,
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    input  op_e               req_op_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic              uncorr_err_i,
    input  logic              irq_ack_i,
    input  logic              cnt_clr_i,
    output logic [CNT_W-1:0]  err_cnt_o,
    output logic              cnt_sat_o,
    output logic              interrupt_o,
    output logic              irq_overrun_o,
    output logic [ADDR_W-1:0] err_addr_o
);

    logic              ev;
    irq_state_e        state_q;
    logic              irq_q;
    logic              overrun_q;
    logic [ADDR_W-1:0] err_addr_q;

    assign ev = req_valid_i && (req_op_i == OP_ADD) && uncorr_err_i;

    add_err_sat_cnt #(
        .W (CNT_W)
    ) u_sat_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (ev),
        .clr_i (cnt_clr_i),
        .cnt_o (err_cnt_o),
        .sat_o (cnt_sat_o)
    );

    // irq_q always tracks the next state being ASSERT, so the pin is a clean flop output.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            irq_q      <= 1'b0;
            overrun_q  <= 1'b0;
            err_addr_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (ev) begin
                        state_q    <= ARM;
                        err_addr_q <= req_addr_i;
                    end
                end
                ARM: begin
                    state_q <= ASSERT;
                    irq_q   <= 1'b1;
                    if (ev) begin
                        overrun_q <= 1'b1;
                    end
                end
                ASSERT: begin
                    if (irq_ack_i) begin
                        irq_q     <= 1'b0;
                        overrun_q <= 1'b0;
                        if (ev) begin
                            state_q    <= ARM;
                            err_addr_q <= req_addr_i;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else if (ev) begin
                        overrun_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    irq_q   <= 1'b0;
                end
            endcase
        end
    end

    assign interrupt_o   = irq_q;
    assign irq_overrun_o = overrun_q;
    assign err_addr_o    = err_addr_q;

endmodule

// File: tb/tb_add_err_irq_ctrl.sv
// Directed scoreboard bench for add_err_irq_ctrl (CNT_W=3 so saturation is reachable).
module tb_add_err_irq_ctrl;
    import add_err_pkg::*;

    localparam int unsigned CNT_W  = 3;
    localparam int unsigned ADDR_W = 32;

    typedef struct {
        logic [CNT_W-1:0]  cnt;
        logic              sat;
        logic              irq;
        logic              ovr;
        logic [ADDR_W-1:0] addr;
        string             tag;
    } exp_t;

    logic              clk;
    logic              rst;
    logic              req_valid;
    op_e               req_op;
    logic [ADDR_W-1:0] req_addr;
    logic              uncorr_err;
    logic              irq_ack;
    logic              cnt_clr;
    logic [CNT_W-1:0]  err_cnt;
    logic              cnt_sat;
    logic              interrupt;
    logic              irq_overrun;
    logic [ADDR_W-1:0] err_addr;

    exp_t sb[$];
    int   checks = 0;
    int   fails  = 0;

    add_err_irq_ctrl #(
        .CNT_W  (CNT_W),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .req_valid_i   (req_valid),
        .req_op_i      (req_op),
        .req_addr_i    (req_addr),
        .uncorr_err_i  (uncorr_err),
        .irq_ack_i     (irq_ack),
        .cnt_clr_i     (cnt_clr),
        .err_cnt_o     (err_cnt),
        .cnt_sat_o     (cnt_sat),
        .interrupt_o   (interrupt),
        .irq_overrun_o (irq_overrun),
        .err_addr_o    (err_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input string field, input logic [31:0] got,
                       input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            fails++;
            $error("FAIL %s.%s got %0h expected %0h", tag, field, got, want);
        end
    endtask

    task automatic push(input logic [CNT_W-1:0] c, input logic s, input logic i,
                        input logic o, input logic [ADDR_W-1:0] a, input string tag);
        exp_t e;
        e.cnt = c; e.sat = s; e.irq = i; e.ovr = o; e.addr = a; e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic pop_check();
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            fails++;
            $error("FAIL scoreboard got empty queue expected entry");
        end else begin
            e = sb.pop_front();
            chk(e.tag, "err_cnt", 32'(err_cnt), 32'(e.cnt));
            chk(e.tag, "cnt_sat", 32'(cnt_sat), 32'(e.sat));
            chk(e.tag, "interrupt", 32'(interrupt), 32'(e.irq));
            chk(e.tag, "irq_overrun", 32'(irq_overrun), 32'(e.ovr));
            chk(e.tag, "err_addr", err_addr, e.addr);
        end
    endtask

    // Drive one cycle of stimulus, queue what must be visible after the edge, then compare.
    task automatic step(input logic v, input op_e op, input logic [ADDR_W-1:0] a,
                        input logic e, input logic ack, input logic clr,
                        input logic [CNT_W-1:0] c, input logic s, input logic i,
                        input logic o, input logic [ADDR_W-1:0] ea, input string tag);
        req_valid = v; req_op = op; req_addr = a; uncorr_err = e;
        irq_ack = ack; cnt_clr = clr;
        push(c, s, i, o, ea, tag);
        @(posedge clk);
        #1;
        pop_check();
    endtask

    task automatic idle(input logic [CNT_W-1:0] c, input logic s, input logic i,
                        input logic o, input logic [ADDR_W-1:0] ea, input string tag);
        step(1'b0, OP_NOP, '0, 1'b0, 1'b0, 1'b0, c, s, i, o, ea, tag);
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_op = OP_NOP; req_addr = '0;
        uncorr_err = 1'b0; irq_ack = 1'b0; cnt_clr = 1'b0;
        #2;
        push(0, 0, 0, 0, 0, "reset");
        pop_check();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Single error: count after one edge, interrupt after two.
        idle(0, 0, 0, 0, 0, "pre0");
        idle(0, 0, 0, 0, 0, "pre1");
        step(1, OP_ADD, 32'h1000_0010, 1, 0, 0, 1, 0, 0, 0, 32'h1000_0010, "single_ev");
        idle(1, 0, 1, 0, 32'h1000_0010, "single_irq");
        step(0, OP_NOP, 0, 0, 1, 0, 1, 0, 0, 0, 32'h1000_0010, "single_ack");

        // Non-qualifying traffic is ignored; ack in IDLE does nothing.
        step(0, OP_NOP, 0, 0, 0, 1, 0, 0, 0, 0, 32'h1000_0010, "clr");
        step(1, OP_SUB, 32'hdead_0000, 1, 0, 0, 0, 0, 0, 0, 32'h1000_0010, "sub_err");
        step(1, OP_ADD, 32'hdead_0004, 0, 0, 0, 0, 0, 0, 0, 32'h1000_0010, "add_noerr");
        step(0, OP_ADD, 32'hdead_0008, 1, 0, 0, 0, 0, 0, 0, 32'h1000_0010, "err_novalid");
        step(0, OP_NOP, 0, 0, 1, 0, 0, 0, 0, 0, 32'h1000_0010, "ack_idle");
        idle(0, 0, 0, 0, 32'h1000_0010, "still_idle");

        // Three back-to-back errors.
        step(1, OP_ADD, 32'h0000_0a00, 1, 0, 0, 1, 0, 0, 0, 32'h0000_0a00, "b2b_1");
        step(1, OP_ADD, 32'h0000_0b00, 1, 0, 0, 2, 0, 1, 1, 32'h0000_0a00, "b2b_2");
        step(1, OP_ADD, 32'h0000_0c00, 1, 0, 0, 3, 0, 1, 1, 32'h0000_0a00, "b2b_3");

        // Ack together with a new error re-arms: one low cycle, overrun cleared.
        step(1, OP_ADD, 32'h0000_0d00, 1, 1, 0, 4, 0, 0, 0, 32'h0000_0d00, "rearm");
        idle(4, 0, 1, 0, 32'h0000_0d00, "rearm_high");
        idle(4, 0, 1, 0, 32'h0000_0d00, "rearm_hold");
        step(1, OP_ADD, 32'h0000_0e00, 1, 1, 0, 5, 0, 0, 0, 32'h0000_0e00, "rearm2");
        step(0, OP_NOP, 0, 0, 1, 0, 5, 0, 1, 0, 32'h0000_0e00, "ack_in_arm");

        // Asynchronous reset while ASSERT with err_cnt=5, checked before any edge.
        rst = 1'b1;
        #1;
        push(0, 0, 0, 0, 0, "async_rst");
        pop_check();
        rst = 1'b0;
        step(1, OP_ADD, 32'h0000_0f00, 1, 0, 0, 1, 0, 0, 0, 32'h0000_0f00, "post_rst_ev");
        idle(1, 0, 1, 0, 32'h0000_0f00, "post_rst_irq");
        step(0, OP_NOP, 0, 0, 1, 0, 1, 0, 0, 0, 32'h0000_0f00, "post_rst_ack");

        // Saturation at 7 then clear-with-increment.
        step(0, OP_NOP, 0, 0, 0, 1, 0, 0, 0, 0, 32'h0000_0f00, "sat_clr0");
        for (int i = 1; i <= 9; i++) begin
            step(1, OP_ADD, 32'h2000 + 32'(i), 1, 0, 0, (i >= 7) ? 3'd7 : 3'(i),
                 (i >= 7), (i >= 2), (i >= 2), 32'h2001, $sformatf("sat_ev%0d", i));
        end
        step(1, OP_ADD, 32'h3000, 1, 0, 1, 1, 0, 1, 1, 32'h2001, "clr_and_ev");
        step(0, OP_NOP, 0, 0, 0, 1, 0, 0, 1, 1, 32'h2001, "clr_alone");
        step(0, OP_NOP, 0, 0, 1, 0, 0, 0, 0, 0, 32'h2001, "final_ack");

        if (sb.size() != 0) begin
            checks++;
            fails++;
            $error("FAIL scoreboard_drain got %0d entries expected 0", sb.size());
        end
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule

// File: doc/add_err_irq_ctrl.md
# add_err_irq_ctrl

Error-accounting and interrupt-generation block for the datapath request port. Monitors every accepted request; when an uncorrectable error coincides with an ADD request it updates a saturating error counter one clock later and raises a level interrupt one clock after that. The interrupt is held until acknowledged by the interrupt-controller or register block. This block is the responder whose timing the existing error-handling assertion checks.

## Interface
- CNT_W, 16: width of err_cnt; saturates at 2**CNT_W-1.
- ADDR_W, 32: width of request address captured on first error.
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request accepted this cycle.
- req_op  in  2  opcode, add_err_pkg::op_e; OP_ADD = 2'b01.
- req_addr  in  ADDR_W  request address.
- uncorr_err  in  1  uncorrectable error flag for the current request.
- irq_ack  in  1  single-cycle pulse; clears interrupt and overrun.
- cnt_clr  in  1  single-cycle pulse; zeroes err_cnt and cnt_sat.
- err_cnt  out  CNT_W  qualifying-error count.
- cnt_sat  out  1  sticky; err_cnt reached max.
- interrupt  out  1  level interrupt.
- irq_overrun  out  1  sticky; qualifying error occurred while interrupt was pending or asserted.
- err_addr  out  ADDR_W  req_addr of the error that armed the current interrupt.

## Operation
- Qualifying event ev = req_valid && req_op==OP_ADD && uncorr_err. Non-ADD ops and uncorr_err without req_valid are ignored.
- Counter: ev at edge T gives err_cnt = old+1 after T. At max it holds; cnt_sat sets. cnt_clr has priority over hold: cnt_clr && ev gives err_cnt = 1, cnt_sat = 0; cnt_clr alone gives 0.
- FSM states (add_err_pkg::irq_state_e):
  - IDLE: on ev, capture err_addr and go to ARM.
  - ARM: interrupt is low. Go to ASSERT unconditionally. ev sets irq_overrun.
  - ASSERT: interrupt is high.
    - irq_ack && !ev: go to IDLE and clear irq_overrun.
    - irq_ack && ev: go to ARM, clear irq_overrun, recapture err_addr.
    - ev without ack: stay in ASSERT and set irq_overrun.
- irq_ack in IDLE or ARM has no effect.
- interrupt is a registered decode of state==ASSERT, so it is glitch-free.
- err_addr is held, not recaptured, while in ARM or ASSERT.

## Timing
- Reset values: err_cnt=0, cnt_sat=0, interrupt=0, irq_overrun=0, err_addr=0, state IDLE.
- Reset is asynchronous and takes effect immediately mid-operation. An ev sampled on the same edge on which rst deasserts-with-recovery is processed normally.
- Latency: ev at edge T gives err_cnt+1 visible after T, state ARM after T, and interrupt=1 after T+1.
- Ack latency: irq_ack at edge T gives interrupt=0 after T. A re-armed interrupt (ack together with ev) reasserts after T+1, so there is exactly one low cycle.
- Back-to-back ev every cycle: count increments every cycle, and one interrupt stays high with overrun set.
- Minimum error-to-interrupt spacing is 2 cycles. Interrupt is never asserted in the same cycle as its triggering count update.

## Structure
- add_err_pkg holds:
  - op_e: OP_NOP=0, OP_ADD=1, OP_SUB=2, OP_MUL=3.
  - irq_state_e: IDLE, ARM, ASSERT.
  - A function returning the counter max for a given width.
- Sub-module add_err_sat_cnt (params W; ports clk, rst, inc, clr, cnt, sat) implements the saturating counter with clear-plus-increment priority.
- The top module contains the FSM, the address capture and the output registers.

## Test plan
- After reset, one ADD+uncorr_err at cycle 3: err_cnt=1 at cycle 4, interrupt=1 at cycle 5, err_addr equals the stimulus address, irq_overrun=0.
- SUB+uncorr_err, then ADD without error, then uncorr_err with req_valid=0: err_cnt stays 0 and interrupt stays 0 throughout.
- Three consecutive ev cycles from IDLE: err_cnt=1,2,3; interrupt=1 from the 2nd cycle after the first ev; irq_overrun=1; err_addr is that of the first ev.
- irq_ack together with ev while ASSERT: interrupt low for exactly one cycle then high again, irq_overrun=0, err_addr updated.
- With CNT_W=3, issue 9 ev then cnt_clr with ev on the same edge: err_cnt reaches 7, cnt_sat=1, then err_cnt=1 and cnt_sat=0.
- Assert rst while ASSERT with err_cnt=5: all outputs 0 immediately without waiting for a clock; a later ev restarts the 1-then-2-cycle sequence.
